vec_mem_seq: RTL and testbench

//  Parametrised data-memory sequencer for RV32IMV AES cores: serves scalar (32-bit, byte-masked) and

---
 rtl/vec_mem_pkg.sv | 30 +++
 rtl/vec_mem_seq_if.sv | 37 +++
 rtl/vec_mem_ram.sv | 30 +++
 rtl/vec_mem_seq.sv | 162 ++++++++++++++++
 tb/tb_vec_mem_seq.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/vec_mem_pkg.sv
// rtl/vec_mem_pkg.sv - shared types and sizing helpers for the vector memory sequencer
package vec_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    LAST,
    RSP
  } state_e;

  localparam int BEAT_W_MIN = 32;
  localparam int BEAT_W_MAX = 64;

  function automatic int nbeat(input int vlen, input int beat_w);
    return vlen / beat_w;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

  function automatic bit beat_w_ok(input int w);
    return (w == BEAT_W_MIN) || (w == BEAT_W_MAX);
  endfunction

endpackage

// File: rtl/vec_mem_seq_if.sv
// rtl/vec_mem_seq_if.sv - CPU request/response bundle; req_emask exists only with VEC_ELEM_MASK_EN
interface vec_mem_seq_if #(
  parameter int VLEN   = 128,
  parameter int BEAT_W = 32,
  parameter int ADDR_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic                  req_vec;
  logic [ADDR_W-1:0]     req_addr;
  logic [VLEN-1:0]       req_wdata;
  logic [BEAT_W/8-1:0]   req_be;
`ifdef VEC_ELEM_MASK_EN
  logic [VLEN/BEAT_W-1:0] req_emask;
`endif
  logic                  rsp_valid;
  logic [VLEN-1:0]       rsp_rdata;
  logic                  busy;

  modport master (
    output req_valid, req_we, req_vec, req_addr, req_wdata, req_be,
`ifdef VEC_ELEM_MASK_EN
    output req_emask,
`endif
    input  req_ready, rsp_valid, rsp_rdata, busy
  );

  modport slave (
    input  req_valid, req_we, req_vec, req_addr, req_wdata, req_be,
`ifdef VEC_ELEM_MASK_EN
    input  req_emask,
`endif
    output req_ready, rsp_valid, rsp_rdata, busy
  );

endinterface

// File: rtl/vec_mem_ram.sv
// rtl/vec_mem_ram.sv - single-port synchronous RAM, DEPTH x BEAT_W, byte write enables, no reset
module vec_mem_ram #(
  parameter int DEPTH  = 1024,
  parameter int BEAT_W = 32
) (
  input  logic                     clk,
  input  logic                     en_i,
  input  logic                     we_i,
  input  logic [BEAT_W/8-1:0]      be_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [BEAT_W-1:0]        wdata_i,
  output logic [BEAT_W-1:0]        rdata_o
);

  localparam int BYTES = BEAT_W / 8;

  logic [BEAT_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int b = 0; b < BYTES; b++) begin
        if (we_i && be_i[b]) begin
          mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
      rdata_o <= mem_q[addr_i];
    end
  end

endmodule

// File: rtl/vec_mem_seq.sv
// rtl/vec_mem_seq.sv - beat-serial scalar/vector load-store sequencer over a BEAT_W RAM
// Optional per-beat element mask enabled by VEC_ELEM_MASK_EN.
module vec_mem_seq
  import vec_mem_pkg::*;
#(
  parameter int VLEN   = 128,
  parameter int BEAT_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic          clk,
  input  logic          clr,
  vec_mem_seq_if.slave  bus
);

  localparam int NB     = nbeat(VLEN, BEAT_W);
  localparam int BYTES  = BEAT_W / 8;
  localparam int BSH    = $clog2(BYTES);
  localparam int RAM_AW = $clog2(DEPTH);
  localparam int CW     = idx_w(NB);

  if ((VLEN % BEAT_W) != 0 || !beat_w_ok(BEAT_W) || !is_pow2(DEPTH)) begin : g_param_err
    $error("vec_mem_seq: VLEN must be a multiple of BEAT_W, BEAT_W 32/64, DEPTH a power of two");
  end

  state_e              state_q;
  logic [CW-1:0]       beat_q;
  logic                we_q;
  logic                vec_q;
  logic [RAM_AW-1:0]   base_q;
  logic [VLEN-1:0]     wdata_q;
  logic [BYTES-1:0]    be_q;
  logic [VLEN-1:0]     asm_q;
  logic                rsp_valid_q;
  logic [VLEN-1:0]     rsp_rdata_q;
`ifdef VEC_ELEM_MASK_EN
  logic [NB-1:0]       emask_q;
`endif

  logic [ADDR_W-1:0]   word_addr;
  logic [CW-1:0]       last_beat;
  logic [CW-1:0]       rd_idx;
  logic                rd_valid;
  logic                wr_beat_en;
  logic                rd_beat_en;
  logic                ram_en;
  logic                ram_we;
  logic [BYTES-1:0]    ram_be;
  logic [RAM_AW-1:0]   ram_addr;
  logic [BEAT_W-1:0]   ram_wdata;
  logic [BEAT_W-1:0]   ram_rdata;
  logic [VLEN-1:0]     asm_d;
  logic                unused_addr_bits;

  assign word_addr        = bus.req_addr >> BSH;
  assign unused_addr_bits = ^word_addr;
  assign last_beat        = vec_q ? CW'(NB - 1) : '0;

  // Read data trails the address by one cycle, so the beat arriving now is the previous one.
  assign rd_idx   = (state_q == LAST) ? last_beat : (beat_q - CW'(1));
  assign rd_valid = !we_q && ((state_q == LAST) || ((state_q == XFER) && (beat_q != '0)));

`ifdef VEC_ELEM_MASK_EN
  assign wr_beat_en = !vec_q || emask_q[beat_q];
  assign rd_beat_en = !vec_q || emask_q[rd_idx];
`else
  assign wr_beat_en = 1'b1;
  assign rd_beat_en = 1'b1;
`endif

  assign ram_en    = (state_q == XFER);
  assign ram_we    = ram_en && we_q && wr_beat_en;
  assign ram_be    = vec_q ? {BYTES{1'b1}} : be_q;
  assign ram_addr  = base_q + RAM_AW'(beat_q);
  assign ram_wdata = wdata_q[int'(beat_q)*BEAT_W +: BEAT_W];

  always_comb begin
    asm_d = asm_q;
    if (rd_valid) begin
      asm_d[int'(rd_idx)*BEAT_W +: BEAT_W] = rd_beat_en ? ram_rdata : '0;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      we_q        <= 1'b0;
      vec_q       <= 1'b0;
      base_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      asm_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef VEC_ELEM_MASK_EN
      emask_q     <= '0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            vec_q   <= bus.req_vec;
            base_q  <= word_addr[RAM_AW-1:0];
            wdata_q <= bus.req_wdata;
            be_q    <= bus.req_be;
`ifdef VEC_ELEM_MASK_EN
            emask_q <= bus.req_emask;
`endif
            beat_q  <= '0;
            asm_q   <= '0;
            state_q <= XFER;
          end
        end
        XFER: begin
          asm_q <= asm_d;
          if (beat_q == last_beat) begin
            beat_q <= '0;
            if (we_q) begin
              state_q     <= RSP;
              rsp_valid_q <= 1'b1;
            end else begin
              state_q <= LAST;
            end
          end else begin
            beat_q <= beat_q + CW'(1);
          end
        end
        LAST: begin
          state_q     <= RSP;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= asm_d;
        end
        RSP: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  vec_mem_ram #(
    .DEPTH  (DEPTH),
    .BEAT_W (BEAT_W)
  ) u_ram (
    .clk     (clk),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .be_i    (ram_be),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  assign bus.req_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_vec_mem_seq.sv
// tb/tb_vec_mem_seq.sv - scoreboard bench for vec_mem_seq (VLEN=128, BEAT_W=32, DEPTH=1024)
module tb_vec_mem_seq;

  localparam int VLEN   = 128;
  localparam int BEAT_W = 32;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 1024;

  typedef struct {
    logic [VLEN-1:0] d;
    int              acc;
    int              lat;
  } exp_t;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_rsp = 0;
  int   n_push = 0;
  int   last_acc = 0;
  logic [VLEN-1:0] hold = '0;
  exp_t exp_q[$];

  vec_mem_seq_if #(.VLEN(VLEN), .BEAT_W(BEAT_W), .ADDR_W(ADDR_W)) bus ();

  vec_mem_seq #(
    .VLEN(VLEN), .BEAT_W(BEAT_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!clr && bus.rsp_valid) begin
      n_rsp++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 at cycle %0d expected no response", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_rdata", bus.rsp_rdata, e.d);
        chk("rsp_cycle", VLEN'(cyc), VLEN'(e.acc + e.lat));
      end
    end
  end

  task automatic issue(input logic we, input logic vec, input logic [ADDR_W-1:0] addr,
                       input logic [VLEN-1:0] wd, input logic [3:0] be, input logic [3:0] em,
                       input logic [VLEN-1:0] exp_d, input bit push);
    exp_t e;
    bit ok = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_vec   = vec;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.req_be    = be;
`ifdef VEC_ELEM_MASK_EN
    bus.req_emask = em;
`endif
    for (int k = 0; k < 50; k++) begin
      if (bus.req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("accept", VLEN'(ok), VLEN'(1));
    @(posedge clk);
    #1;
    last_acc = cyc;
    if (push) begin
      if (!we) hold = exp_d;
      e.d   = hold;
      e.acc = cyc;
      e.lat = (vec ? 4 : 1) + (we ? 0 : 1);
      exp_q.push_back(e);
      n_push++;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    bit done = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = ~bus.req_we;
    bus.req_addr  = 32'hFFFF_FFFF;
    bus.req_wdata = {4{32'hBAD0_BAD0}};
    bus.req_be    = 4'h0;
    for (int k = 0; k < 50; k++) begin
      if (exp_q.size() == 0 && bus.req_ready) begin
        done = 1'b1;
        break;
      end
      if (exp_q.size() != 0) chk("ready_low_while_busy", VLEN'({bus.req_ready, bus.busy}), VLEN'(2'b01));
      @(negedge clk);
    end
    chk("drain_done", VLEN'(done), VLEN'(1));
  endtask

  initial begin
    logic [VLEN-1:0] p1, p2, d, vz;
    int a1;
    p1 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    p2 = 128'h44444444_33333333_22222222_11111111;
    d  = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C;
    vz = '0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_vec   = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
`ifdef VEC_ELEM_MASK_EN
    bus.req_emask = '0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_ready_busy", VLEN'({bus.req_ready, bus.busy, bus.rsp_valid}), VLEN'(3'b100));
    chk("reset_rdata", bus.rsp_rdata, vz);
    clr = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", VLEN'({bus.req_ready, bus.busy}), VLEN'(2'b10));

    // scalar byte-masked store over a zeroed word
    issue(1, 0, 32'h10, vz, 4'hF, 4'hF, vz, 1); drain();
    issue(1, 0, 32'h10, 128'hDEADBEEF, 4'b0101, 4'hF, vz, 1); drain();
    issue(0, 0, 32'h10, vz, 4'h0, 4'hF, 128'h00AD00EF, 1); drain();

    // vector store/load, plus scalar peeks into the written words
    issue(1, 1, 32'h20, p1, 4'h0, 4'hF, vz, 1); drain();
    issue(0, 1, 32'h20, vz, 4'h0, 4'hF, p1, 1); drain();
    issue(0, 0, 32'h2C, vz, 4'h0, 4'hF, 128'h0F0E0D0C, 1); drain();
    issue(0, 0, 32'h27, vz, 4'h0, 4'hF, 128'h07060504, 1); drain();

    // wrap-around from word DEPTH-2
    issue(1, 1, (DEPTH - 2) * 4, p2, 4'h0, 4'hF, vz, 1); drain();
    issue(0, 1, (DEPTH - 2) * 4, vz, 4'h0, 4'hF, p2, 1); drain();
    issue(0, 0, 32'h0, vz, 4'h0, 4'hF, 128'h33333333, 1); drain();
    issue(0, 0, 32'h4, vz, 4'h0, 4'hF, 128'h44444444, 1); drain();

    // req_valid held through RSP: second request waits for IDLE
    issue(1, 0, 32'h30, 128'h12345678, 4'hF, 4'hF, vz, 1);
    a1 = last_acc;
    issue(0, 0, 32'h30, {4{32'hFFFF_FFFF}}, 4'hF, 4'hF, 128'h12345678, 1);
    chk("held_valid_accept_gap", VLEN'(last_acc - a1), VLEN'(3));
    drain();

    // reset mid vector store: only beats 0,1 land
    issue(1, 1, 32'h0, p1, 4'h0, 4'hF, vz, 1); drain();
    issue(1, 1, 32'h0, p2, 4'h0, 4'hF, vz, 0);
    bus.req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 clr = 1'b1;
    #1;
    chk("midburst_clr_state", VLEN'({bus.req_ready, bus.busy, bus.rsp_valid}), VLEN'(3'b100));
    chk("midburst_clr_rdata", bus.rsp_rdata, vz);
    hold = '0;
    @(negedge clk);
    clr = 1'b0;
    repeat (6) @(negedge clk);
    issue(0, 1, 32'h0, vz, 4'h0, 4'hF, {p1[127:64], p2[63:0]}, 1); drain();

`ifdef VEC_ELEM_MASK_EN
    issue(1, 1, 32'h40, vz, 4'h0, 4'hF, vz, 1); drain();
    issue(1, 1, 32'h40, d, 4'h0, 4'b1010, vz, 1); drain();
    issue(0, 1, 32'h40, vz, 4'h0, 4'hF, {d[127:96], 32'h0, d[63:32], 32'h0}, 1); drain();
    issue(0, 1, 32'h40, vz, 4'h0, 4'b0011, {64'h0, d[63:32], 32'h0}, 1); drain();
    issue(0, 0, 32'h40, vz, 4'h0, 4'b0000, 128'h0, 1); drain();
`else
    issue(1, 1, 32'h40, d, 4'h0, 4'h0, vz, 1); drain();
    issue(0, 1, 32'h40, vz, 4'h0, 4'h0, d, 1); drain();
`endif

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", VLEN'(exp_q.size()), VLEN'(0));
    chk("rsp_count", VLEN'(n_rsp), VLEN'(n_push));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation time limit expected test completion");
    $fatal(1);
  end

endmodule
